// File: rtl/sram_access_arbiter.sv
// Four-way SRAM_controller arbiter (0=VGA, 1=UART, 2=M2, 3=M1).
// Define SRAM_ARB_RR_EN for round-robin among requesters 1..3; otherwise fixed priority.
module sram_access_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int MAX_HOLD     = 0
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [17:0] req_address    [3:0],
    input  logic [15:0] req_write_data [3:0],
    input  logic [3:0]  req_we_n,
    output logic [3:0]  gnt,
    output logic [1:0]  owner_id,
    output logic        busy,
    output logic [3:0]  rd_valid,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

    arb_state_e  state_q;
    logic [3:0]  gnt_q;
    logic [3:0]  req_q;
    logic [1:0]  owner_q;
    logic [15:0] hold_q;
    logic [1:0]  win_d;
    logic        rel_d;
    logic        rd_issue;
    logic [2:0]  tag_q [READ_LATENCY];

`ifdef SRAM_ARB_RR_EN
    logic [1:0] rr_q;
    logic [1:0] rr_d;
    logic [2:0] rr_idx;
    logic       rr_found;

    always_comb begin
        win_d    = 2'd0;
        rr_found = 1'b0;
        rr_idx   = 3'd0;
        rr_d     = owner_q + 2'd1;
        if (rr_d == 2'd0) rr_d = 2'd1;
        if (!req_q[0]) begin
            for (int k = 0; k < 3; k++) begin
                rr_idx = {1'b0, rr_q} + 3'(k);
                if (rr_idx > 3'd3) rr_idx = rr_idx - 3'd3;
                if (!rr_found && req_q[rr_idx[1:0]]) begin
                    win_d    = rr_idx[1:0];
                    rr_found = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        win_d = 2'd0;
        priority case (1'b1)
            req_q[0]: win_d = 2'd0;
            req_q[1]: win_d = 2'd1;
            req_q[2]: win_d = 2'd2;
            req_q[3]: win_d = 2'd3;
            default:  win_d = 2'd0;
        endcase
    end
`endif

    // Forced release only matters when someone else is actually waiting.
    always_comb begin
        rel_d = !req[owner_q];
        if (MAX_HOLD != 0 && hold_q == 16'(MAX_HOLD - 1)
            && (req & ~gnt_q) != 4'd0)
            rel_d = 1'b1;
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 4'd0;
            req_q   <= 4'd0;
            owner_q <= 2'd0;
            hold_q  <= 16'd0;
`ifdef SRAM_ARB_RR_EN
            rr_q    <= 2'd1;
`endif
        end else begin
            req_q <= req;
            unique case (state_q)
                ARB_IDLE: begin
                    if (req_q != 4'd0) begin
                        gnt_q   <= 4'b0001 << win_d;
                        owner_q <= win_d;
                        hold_q  <= 16'd0;
                        state_q <= ARB_OWN;
                    end
                end
                ARB_OWN: begin
                    if (hold_q != 16'hFFFF) hold_q <= hold_q + 16'd1;
                    if (rel_d) begin
                        gnt_q   <= 4'd0;
                        state_q <= ARB_IDLE;
`ifdef SRAM_ARB_RR_EN
                        rr_q    <= rr_d;
`endif
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign owner_id = owner_q;
    assign busy     = gnt_q != 4'd0;

    always_comb begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        if (busy) begin
            SRAM_address    = req_address[owner_q];
            SRAM_write_data = req_write_data[owner_q];
            SRAM_we_n       = req_we_n[owner_q];
        end
    end

    assign rd_issue = busy && SRAM_we_n;

    // Tags keep flowing after release so late reads still return.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= 3'd0;
        end else begin
            tag_q[0] <= {rd_issue, owner_q};
            for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign rd_valid = tag_q[READ_LATENCY-1][2]
                    ? (4'b0001 << tag_q[READ_LATENCY-1][1:0]) : 4'd0;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter (MAX_HOLD=4, READ_LATENCY=2).
// Read-valid expectations flow through a scoreboard queue.
module tb_sram_access_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [17:0] req_address    [3:0];
    logic [15:0] req_write_data [3:0];
    logic [3:0]  req_we_n;
    logic [3:0]  gnt;
    logic [1:0]  owner_id;
    logic        busy;
    logic [3:0]  rd_valid;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q [$];
    logic [3:0] ord [5];
    logic [3:0] g5;

    sram_access_arbiter #(.READ_LATENCY(LAT), .MAX_HOLD(4)) dut (
        .CLOCK_50_I      (clk),
        .resetn          (resetn),
        .req             (req),
        .req_address     (req_address),
        .req_write_data  (req_write_data),
        .req_we_n        (req_we_n),
        .gnt             (gnt),
        .owner_id        (owner_id),
        .busy            (busy),
        .rd_valid        (rd_valid),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prime();
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back(4'd0);
    endtask

    // Check this cycle against expected grant, then advance one clock.
    task automatic step(input logic [3:0] eg, input string tag);
        logic [17:0] ea;
        logic [15:0] ed;
        logic        ew;
        logic [1:0]  eo;
        logic [3:0]  iss;
        logic [3:0]  erd;
        #1;
        ea = '0; ed = '0; ew = 1'b1; eo = '0; iss = '0;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) begin
                ea = req_address[i];
                ed = req_write_data[i];
                ew = req_we_n[i];
                eo = 2'(i);
                iss[i] = req_we_n[i];
            end
        end
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".busy"}, 32'(busy), 32'(eg != 4'd0));
        chk({tag, ".addr"}, 32'(SRAM_address), 32'(ea));
        chk({tag, ".wdata"}, 32'(SRAM_write_data), 32'(ed));
        chk({tag, ".we_n"}, 32'(SRAM_we_n), 32'(ew));
        if (eg != 4'd0) chk({tag, ".owner"}, 32'(owner_id), 32'(eo));
        exp_q.push_back(iss);
        @(posedge clk);
        #1;
        erd = exp_q.pop_front();
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(erd));
    endtask

    initial begin
`ifdef SRAM_ARB_RR_EN
        ord = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100};
        g5  = 4'b1000;
`else
        ord = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        g5  = 4'b0010;
`endif
        resetn   = 1'b0;
        req      = 4'b0100;
        req_we_n = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_address[i]    = 18'(18'h01000 * (i + 1));
            req_write_data[i] = 16'(16'hA000 + i);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.we_n", 32'(SRAM_we_n), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.rd_valid", 32'(rd_valid), 32'd0);
        chk("rst.addr", 32'(SRAM_address), 32'd0);

        // Reset release with req held, then owner 2 reads back to back
        resetn = 1'b1;
        prime();
        step(4'b0000, "t1.a");
        step(4'b0000, "t1.edge1");
        req_address[2] = 18'h00010;
        step(4'b0100, "t2.rd10");
        req_address[2] = 18'h00011;
        step(4'b0100, "t2.rd11");
        req = 4'b0000;
        step(4'b0100, "t2.drop");
        step(4'b0000, "t2.idle0");
        step(4'b0000, "t2.idle1");

        // Owner 1 writes while non-owner 3 drives a write
        req = 4'b0010;
        step(4'b0000, "t5.h");
        step(4'b0000, "t5.i");
        req = 4'b1010;
        req_we_n = 4'b0101;
        req_address[1] = 18'h00123;
        req_address[3] = 18'h3FFFF;
        req_write_data[1] = 16'hBEEF;
        req_write_data[3] = 16'hDEAD;
        step(4'b0010, "t5.w0");
        step(4'b0010, "t5.w1");
        step(4'b0010, "t5.w2");
        step(4'b0010, "t5.w3");
        step(4'b0000, "t5.gap");
        step(g5, "t5.regrant");
        step(g5, "t5.own");

        // Asynchronous reset mid-write
        resetn = 1'b0;
        #1;
        chk("t6.gnt", 32'(gnt), 32'd0);
        chk("t6.we_n", 32'(SRAM_we_n), 32'd1);
        chk("t6.busy", 32'(busy), 32'd0);
        chk("t6.rd_valid", 32'(rd_valid), 32'd0);
        chk("t6.addr", 32'(SRAM_address), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        req = 4'b0010;
        req_we_n = 4'hF;
        prime();

        // Priority: owner 1 drops, then 0 wins over 3 until it stops
        step(4'b0000, "t4.a");
        step(4'b0000, "t4.b");
        step(4'b0010, "t4.c");
        req = 4'b1011;
        step(4'b0010, "t4.d");
        req = 4'b1001;
        step(4'b0010, "t4.e");
        step(4'b0000, "t4.gap");
        for (int i = 0; i < 4; i++) step(4'b0001, "t4.own0");
        step(4'b0000, "t4.gap2");
        req = 4'b1000;
        step(4'b0001, "t4.own0b");
        step(4'b0000, "t4.gap3");
        req = 4'b0000;
        step(4'b1000, "t4.own3");
        step(4'b0000, "t4.end");

        // Contention 1110 with forced release every 4 cycles
        req = 4'b1110;
        step(4'b0000, "t3.p");
        step(4'b0000, "t3.q");
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 5; c++) begin
                if (t == 3 && c == 4) req = 4'b0000;
                step(c < 4 ? ord[t] : 4'b0000, "t3.tenure");
            end
        end
        step(ord[4], "t3.last");
        step(4'b0000, "t3.done");
        step(4'b0000, "t3.drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
